// File: rtl/fetch_pkg.sv
// Shared types for the prefetching instruction fetch unit.
package fetch_pkg;

  localparam int unsigned FETCH_XLEN = 32;
  localparam logic [1:0]  INST_ALIGN_MASK = 2'b11;

  typedef enum logic [1:0] {
    FILL,
    HOLD,
    SQUASH,
    FAULT
  } FETCH_STATE;

  typedef struct packed {
    logic [FETCH_XLEN-1:0] pc;
    logic [FETCH_XLEN-1:0] ir;
  } fetch_entry_t;

endpackage

// File: rtl/wb4_if.sv
// Wishbone B4 classic bus bundle used by the instruction fetch path.
interface WB4 #(
  parameter int unsigned AW = 32,
  parameter int unsigned DW = 32
) (
  input logic clk,
  input logic rst
);
  logic          CYC;
  logic          STB;
  logic          WE;
  logic [AW-1:0] ADR;
  logic [DW-1:0] DAT_O;
  logic          ACK;
  logic [DW-1:0] DAT_I;

  modport master (input clk, rst, ACK, DAT_I, output CYC, STB, WE, ADR, DAT_O);
  modport slave  (input clk, rst, CYC, STB, WE, ADR, DAT_O, output ACK, DAT_I);
endinterface

// File: rtl/fetch_fifo.sv
// Fall-through FIFO of {pc, ir} entries; head is visible without a pop.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter  int unsigned DEPTH = 4,
  localparam int unsigned CW    = $clog2(DEPTH + 1),
  localparam int unsigned AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic          flush,
  input  fetch_entry_t  din,
  output fetch_entry_t  head,
  output logic [CW-1:0] count,
  output logic          empty,
  output logic          full
);

  fetch_entry_t   mem [DEPTH];
  logic [AW-1:0]  rd_ptr;
  logic [AW-1:0]  wr_ptr;
  logic           do_push;
  logic           do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty && !flush;
  assign head    = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      unique case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/fetch_prefetch.sv
// Prefetching instruction fetch unit: streams WB4 reads into a queue and
// hands {PC, IR} to execute over valid/ready; jumps flush and redirect.
module fetch_prefetch
  import fetch_pkg::*;
#(
  parameter  int unsigned     XLEN            = FETCH_XLEN,
  parameter  logic [XLEN-1:0] PC_RESET_VECTOR = '0,
  parameter  int unsigned     QUEUE_DEPTH     = 4,
  localparam int unsigned     CW              = $clog2(QUEUE_DEPTH + 1)
) (
  input  logic            clk,
  input  logic            rst,
  WB4.master              inst_bus,
  input  logic            jump,
  input  logic [XLEN-1:0] jump_target,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [XLEN-1:0] PC_O,
  output logic [XLEN-1:0] IR_O,
  output logic [CW-1:0]   queue_count,
  output logic            fetch_fault
);

  FETCH_STATE      state;
  logic [XLEN-1:0] fetch_pc;
  logic [XLEN-1:0] squash_adr;
  logic            fault_q;
  logic            ack;
  logic            jump_misaligned;
  logic            bus_req;
  logic            push;
  logic            pop;
  logic            q_empty;
  logic            q_full;
  logic [CW:0]     count_after;
  fetch_entry_t    q_din;
  fetch_entry_t    q_head;

  assign ack             = inst_bus.ACK;
  assign jump_misaligned = |(jump_target[1:0] & INST_ALIGN_MASK);
  assign bus_req         = !rst && (state == FILL || state == SQUASH);

  assign inst_bus.CYC   = bus_req;
  assign inst_bus.STB   = bus_req;
  assign inst_bus.WE    = 1'b0;
  assign inst_bus.DAT_O = '0;
  assign inst_bus.ADR   = (state == SQUASH) ? squash_adr : fetch_pc;

  assign pop         = inst_valid && inst_ready;
  assign push        = (state == FILL) && ack && !jump;
  assign q_din       = '{pc: fetch_pc, ir: inst_bus.DAT_I};
  assign count_after = {1'b0, queue_count} + (CW + 1)'(push) - (CW + 1)'(pop);

  fetch_fifo #(
    .DEPTH(QUEUE_DEPTH)
  ) u_fifo (
    .clk  (clk),
    .rst  (rst),
    .push (push),
    .pop  (pop),
    .flush(jump),
    .din  (q_din),
    .head (q_head),
    .count(queue_count),
    .empty(q_empty),
    .full (q_full)
  );

  assign inst_valid  = !q_empty;
  assign PC_O        = q_head.pc;
  assign IR_O        = q_head.ir;
  assign fetch_fault = fault_q;

  // During SQUASH the bus keeps the stored old address while fetch_pc
  // already holds the pending target, so later jumps just overwrite it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= FILL;
      fetch_pc   <= PC_RESET_VECTOR;
      squash_adr <= '0;
      fault_q    <= 1'b0;
    end else begin
      if (jump) begin
        fetch_pc <= jump_target;
        fault_q  <= jump_misaligned;
      end
      unique case (state)
        FILL: begin
          if (jump) begin
            if (!ack) begin
              squash_adr <= fetch_pc;
              state      <= SQUASH;
            end else if (jump_misaligned) begin
              state <= FAULT;
            end
          end else if (ack) begin
            fetch_pc <= fetch_pc + XLEN'(4);
            if (count_after == (CW + 1)'(QUEUE_DEPTH)) state <= HOLD;
          end
        end
        HOLD, FAULT: begin
          if (jump) state <= jump_misaligned ? FAULT : FILL;
          else if (state == HOLD && queue_count < CW'(QUEUE_DEPTH)) state <= FILL;
        end
        SQUASH: begin
          if (ack) state <= (jump ? jump_misaligned : fault_q) ? FAULT : FILL;
        end
        default: state <= FILL;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_prefetch.sv
// Directed and randomized bench for fetch_prefetch with a WB4 slave model.
module tb_fetch_prefetch;

  localparam logic [31:0] K = 32'hA5A5A5A5;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        jump = 1'b0;
  logic [31:0] jump_target = '0;
  logic        inst_valid;
  logic        inst_ready = 1'b1;
  logic [31:0] PC_O;
  logic [31:0] IR_O;
  logic [2:0]  queue_count;
  logic        fetch_fault;

  int unsigned wait_states = 0;
  int unsigned wcnt;
  bit          rand_mode = 1'b0;
  bit          ack_rand = 1'b0;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  WB4 #(.AW(32), .DW(32)) bus (.clk(clk), .rst(rst));

  fetch_prefetch #(
    .XLEN(32),
    .PC_RESET_VECTOR(32'h0),
    .QUEUE_DEPTH(4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .inst_bus   (bus),
    .jump       (jump),
    .jump_target(jump_target),
    .inst_valid (inst_valid),
    .inst_ready (inst_ready),
    .PC_O       (PC_O),
    .IR_O       (IR_O),
    .queue_count(queue_count),
    .fetch_fault(fetch_fault)
  );

  // Slave: data is the address scrambled by K; ACK after wait_states cycles or at random.
  assign bus.ACK   = bus.CYC && bus.STB && (rand_mode ? ack_rand : (wcnt >= wait_states));
  assign bus.DAT_I = bus.ACK ? (bus.ADR ^ K) : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) wcnt <= 0;
    else if (bus.CYC && bus.STB && !bus.ACK) wcnt <= wcnt + 1;
    else wcnt <= 0;
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wait_req(input logic [31:0] a, input bit need_ack, input string tag);
    int unsigned n = 0;
    while (!(bus.CYC && bus.ADR == a && (!need_ack || bus.ACK)) && n < 60) begin
      step();
      n++;
    end
    chk(tag, {31'b0, n < 60}, 32'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned acks;
    int unsigned n;
    int unsigned pops;
    logic [31:0] exp_pc;
    logic [31:0] t;
    bit          jmp;

    // Reset values and zero-wait streaming
    step();
    step();
    chk("rst_cyc", {31'b0, bus.CYC}, 32'd0);
    chk("rst_valid", {31'b0, inst_valid}, 32'd0);
    chk("rst_count", {29'b0, queue_count}, 32'd0);
    chk("rst_fault", {31'b0, fetch_fault}, 32'd0);
    chk("rst_pc", PC_O, 32'd0);
    chk("rst_ir", IR_O, 32'd0);
    rst = 1'b0;
    #1;
    chk("first_cyc", {31'b0, bus.CYC}, 32'd1);
    chk("first_adr", bus.ADR, 32'h0);
    chk("first_valid", {31'b0, inst_valid}, 32'd0);
    step();
    chk("lat_valid", {31'b0, inst_valid}, 32'd1);
    for (int i = 0; i < 4; i++) begin
      chk("stream_pc", PC_O, 32'(i * 4));
      chk("stream_ir", IR_O, 32'(i * 4) ^ K);
      if (i < 3) step();
    end

    // Queue fills with no consumer, then resumes
    rst = 1'b1;
    inst_ready = 1'b0;
    step();
    rst = 1'b0;
    #1;
    acks = 0;
    for (int i = 0; i < 12; i++) begin
      if (bus.ACK) acks++;
      step();
    end
    chk("hold_acks", acks, 32'd4);
    chk("hold_cyc", {31'b0, bus.CYC}, 32'd0);
    chk("hold_count", {29'b0, queue_count}, 32'd4);
    chk("hold_head", PC_O, 32'h0);
    inst_ready = 1'b1;
    n = 0;
    while (!bus.CYC && n < 5) begin step(); n++; end
    chk("resume_cyc", {31'b0, bus.CYC}, 32'd1);
    chk("resume_adr", bus.ADR, 32'h10);

    // Jump during a 3-wait-state read of 0x8 needs a squash
    rst = 1'b1;
    step();
    wait_states = 3;
    rst = 1'b0;
    wait_req(32'h8, 1'b0, "req8");
    step();
    jump = 1'b1;
    jump_target = 32'h100;
    step();
    jump = 1'b0;
    n = 0;
    while (bus.ADR == 32'h8 && n < 10) begin
      chk("sq_cyc", {31'b0, bus.CYC}, 32'd1);
      chk("sq_valid", {31'b0, inst_valid}, 32'd0);
      step();
      n++;
    end
    chk("sq_len", n, 32'd2);
    chk("sq_adr", bus.ADR, 32'h100);
    n = 0;
    while (!inst_valid && n < 20) begin step(); n++; end
    chk("sq_pc", PC_O, 32'h100);
    chk("sq_ir", IR_O, 32'h100 ^ K);

    // Jump coinciding with the ACK of 0x4: no squash
    rst = 1'b1;
    step();
    wait_states = 0;
    rst = 1'b0;
    wait_req(32'h4, 1'b1, "ack4");
    jump = 1'b1;
    jump_target = 32'h40;
    step();
    jump = 1'b0;
    chk("j_adr", bus.ADR, 32'h40);
    chk("j_cyc", {31'b0, bus.CYC}, 32'd1);
    chk("j_valid", {31'b0, inst_valid}, 32'd0);
    chk("j_count", {29'b0, queue_count}, 32'd0);
    step();
    chk("j_valid2", {31'b0, inst_valid}, 32'd1);
    chk("j_pc", PC_O, 32'h40);

    // Misaligned jump faults; aligned jump recovers
    jump = 1'b1;
    jump_target = 32'h102;
    step();
    jump = 1'b0;
    for (int i = 0; i < 6; i++) begin
      chk("f_fault", {31'b0, fetch_fault}, 32'd1);
      chk("f_cyc", {31'b0, bus.CYC}, 32'd0);
      chk("f_valid", {31'b0, inst_valid}, 32'd0);
      step();
    end
    jump = 1'b1;
    jump_target = 32'h200;
    step();
    jump = 1'b0;
    chk("f_clear", {31'b0, fetch_fault}, 32'd0);
    chk("f_adr", bus.ADR, 32'h200);
    chk("f_cyc2", {31'b0, bus.CYC}, 32'd1);

    // Misaligned jump mid-wait: squash, then fault
    wait_states = 3;
    wait_req(32'h204, 1'b0, "req204");
    step();
    jump = 1'b1;
    jump_target = 32'h301;
    step();
    jump = 1'b0;
    chk("sf_fault", {31'b0, fetch_fault}, 32'd1);
    chk("sf_cyc", {31'b0, bus.CYC}, 32'd1);
    chk("sf_adr", bus.ADR, 32'h204);
    n = 0;
    while (bus.CYC && n < 10) begin step(); n++; end
    chk("sf_drop", {31'b0, bus.CYC}, 32'd0);
    step();
    chk("sf_idle", {31'b0, bus.CYC}, 32'd0);
    chk("sf_valid", {31'b0, inst_valid}, 32'd0);

    // Reset in a wait state on 0xC
    rst = 1'b1;
    step();
    inst_ready = 1'b0;
    rst = 1'b0;
    wait_req(32'hC, 1'b0, "reqC");
    chk("pre_count", {29'b0, queue_count}, 32'd3);
    step();
    rst = 1'b1;
    #1;
    chk("r_cyc", {31'b0, bus.CYC}, 32'd0);
    chk("r_count", {29'b0, queue_count}, 32'd0);
    chk("r_valid", {31'b0, inst_valid}, 32'd0);
    chk("r_fault", {31'b0, fetch_fault}, 32'd0);
    step();
    rst = 1'b0;
    #1;
    chk("r_cyc2", {31'b0, bus.CYC}, 32'd1);
    chk("r_adr", bus.ADR, 32'h0);

    // Random ACK/ready/jump traffic against an in-order stream model
    rst = 1'b1;
    step();
    rand_mode = 1'b1;
    rst = 1'b0;
    exp_pc = 32'h0;
    pops = 0;
    for (int i = 0; i < 3000; i++) begin
      ack_rand   = ($urandom_range(0, 2) != 0);
      inst_ready = ($urandom_range(0, 3) != 0);
      jmp        = ($urandom_range(0, 39) == 0);
      #1;
      if (inst_valid && inst_ready) begin
        chk("rnd_pc", PC_O, exp_pc);
        chk("rnd_ir", IR_O, exp_pc ^ K);
        exp_pc = exp_pc + 32'd4;
        pops++;
      end
      if (jmp) begin
        t = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF8 : ($urandom & 32'h0000_FFFC);
        jump = 1'b1;
        jump_target = t;
        exp_pc = t;
      end else begin
        jump = 1'b0;
      end
      step();
    end
    jump = 1'b0;
    chk("rnd_pops", {31'b0, pops > 500}, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
